// File: rtl/ntt_stage_scheduler.sv
// NTT stage scheduler: five-stage issue/drain sequencer for a 4-bank 512-point NTT/INTT.
// Optional macro NTT_SCHED_STALL_EN adds a hold input that freezes issue while in RUN.
module ntt_stage_scheduler #(
  parameter int LAT = 13,
  parameter int NPT = 128
) (
  input  logic       clk,
  input  logic       rst,
`ifdef NTT_SCHED_STALL_EN
  input  logic       hold,
`endif
  input  logic       start,
  input  logic [3:0] conf,
  output logic [2:0] p,
  output logic [6:0] k,
  output logic       sel,
  output logic       ren,
  output logic       wen,
  output logic       en,
  output logic       busy,
  output logic [1:0] done_flag
);

  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t         state;
  state_t         nxt;
  logic           mode;
  logic [DW-1:0]  dcnt;
  logic [LAT-1:0] line;
  logic           stall;
  logic           k_last;
  logic           d_last;
  logic           p_last;
  logic           unused_conf;

  assign unused_conf = ^conf[3:1];

`ifdef NTT_SCHED_STALL_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  assign k_last = (k == 7'(NPT - 1));
  assign d_last = (dcnt == DW'(LAT - 1));
  assign p_last = (p == 3'd4);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (!stall && k_last) nxt = DRAIN;
      DRAIN:   if (d_last) nxt = p_last ? DONE : RUN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    ren  = (state == RUN) && !stall;
    busy = (state == RUN) || (state == DRAIN);
    en   = busy;
    sel  = busy && (mode ? (p == 3'd0) : (p == 3'd4));
  end

  // mode latch, issue/stage/drain counters and completion flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode      <= 1'b0;
      p         <= 3'd0;
      k         <= 7'd0;
      dcnt      <= '0;
      done_flag <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mode      <= conf[0];
            p         <= 3'd0;
            k         <= 7'd0;
            dcnt      <= '0;
            done_flag <= 2'b00;
          end
        end
        RUN: begin
          if (!stall) k <= k_last ? 7'd0 : k + 7'd1;
        end
        DRAIN: begin
          if (d_last) begin
            dcnt <= '0;
            if (!p_last) p <= p + 3'd1;
            else done_flag <= mode ? 2'b10 : 2'b01;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // write strobe: ren delayed through a LAT-deep line
  always_ff @(posedge clk) begin
    if (!rst) line <= '0;
    else      line <= (line << 1) | LAT'(ren);
  end

  assign wen = line[LAT-1];

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Directed self-checking bench for ntt_stage_scheduler.
// Covers reset, NTT/INTT runs, stray start, mid-run reset and optional hold.
module tb_ntt_stage_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hold = 1'b0;
  logic       start = 1'b0;
  logic [3:0] conf = 4'b0;
  logic [2:0] p;
  logic [6:0] k;
  logic       sel;
  logic       ren;
  logic       wen;
  logic       en;
  logic       busy;
  logic [1:0] done_flag;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;
  int sel_bad = 0;
  int bnd_seen = 0;
  int bnd_bad = 0;
  int range_bad = 0;
  int last_wen_cyc = -1;
  int prev_k = 0;
  int prev_p = 0;
  logic mode_tb = 1'b0;

  ntt_stage_scheduler dut (
    .clk       (clk),
    .rst       (rst),
`ifdef NTT_SCHED_STALL_EN
    .hold      (hold),
`endif
    .start     (start),
    .conf      (conf),
    .p         (p),
    .k         (k),
    .sel       (sel),
    .ren       (ren),
    .wen       (wen),
    .en        (en),
    .busy      (busy),
    .done_flag (done_flag)
  );

  always #5 clk = ~clk;

  // mid-cycle monitor: strobe counts, sel rule, stage boundaries
  always @(negedge clk) begin
    cyc++;
    if (busy) begin
      if (sel !== (mode_tb ? (p == 3'd0) : (p == 3'd4))) sel_bad++;
    end else if (sel !== 1'b0) begin
      sel_bad++;
    end
    if (k > 7'd127 || p > 3'd4) range_bad++;
    if (ren) begin
      ren_cnt++;
      if (k == 7'd0 && p != 3'd0) begin
        bnd_seen++;
        if (!(last_wen_cyc < cyc && prev_k == 127 && prev_p == int'(p) - 1))
          bnd_bad++;
      end
      prev_k = int'(k);
      prev_p = int'(p);
    end
    if (wen) begin
      wen_cnt++;
      last_wen_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int b_ren, b_wen, b_sel, b_bseen, b_bbad, b_rng;

  task automatic snap();
    b_ren   = ren_cnt;
    b_wen   = wen_cnt;
    b_sel   = sel_bad;
    b_bseen = bnd_seen;
    b_bbad  = bnd_bad;
    b_rng   = range_bad;
  endtask

  // one transform; poke = cycle of stray start, hold_at = first hold cycle
  task automatic run_xfer(input logic [3:0] cv, input int poke,
                          input int hold_at, output int n);
    @(posedge clk); #1;
    start = 1'b1;
    conf = cv;
    mode_tb = cv[0];
    snap();
    @(posedge clk); #1;
    start = 1'b0;
    conf = 4'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_clr", 32'(done_flag), 32'd0);
    n = 0;
    while (done_flag == 2'b00 && n < 2000) begin
      if (n == poke) begin
        start = 1'b1;
        conf = ~cv;
      end else if (n == poke + 1) begin
        start = 1'b0;
        conf = 4'b0;
      end
      if (n == hold_at) hold = 1'b1;
      else if (n == hold_at + 10) hold = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p", 32'(p), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_strobes", 32'({sel, ren, wen, en, busy}), 32'd0);
    check("rst_done", 32'(done_flag), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    run_xfer(4'b0000, -100, -100, n);
    check("ntt_latency", 32'(n), 32'd705);
    check("ntt_flag", 32'(done_flag), 32'd1);
    check("ntt_busy_low", 32'({busy, en}), 32'd0);
    check("ntt_ren", 32'(ren_cnt - b_ren), 32'd640);
    check("ntt_wen", 32'(wen_cnt - b_wen), 32'd640);
    check("ntt_sel", 32'(sel_bad - b_sel), 32'd0);
    check("ntt_bnd_seen", 32'(bnd_seen - b_bseen), 32'd4);
    check("ntt_bnd_bad", 32'(bnd_bad - b_bbad), 32'd0);
    check("ntt_range", 32'(range_bad - b_rng), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("flag_hold", 32'(done_flag), 32'd1);
    check("idle_wen", 32'({wen, ren, busy}), 32'd0);

    run_xfer(4'b1111, -100, -100, n);
    check("intt_latency", 32'(n), 32'd705);
    check("intt_flag", 32'(done_flag), 32'd2);
    check("intt_ren", 32'(ren_cnt - b_ren), 32'd640);
    check("intt_wen", 32'(wen_cnt - b_wen), 32'd640);
    check("intt_sel", 32'(sel_bad - b_sel), 32'd0);
    check("intt_bnd_bad", 32'(bnd_bad - b_bbad), 32'd0);

    run_xfer(4'b0000, 300, -100, n);
    check("poke_latency", 32'(n), 32'd705);
    check("poke_flag", 32'(done_flag), 32'd1);
    check("poke_ren", 32'(ren_cnt - b_ren), 32'd640);
    check("poke_sel", 32'(sel_bad - b_sel), 32'd0);

    @(posedge clk); #1;
    start = 1'b1;
    conf = 4'b0000;
    mode_tb = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (199) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mid_rst_pk", 32'({p, k}), 32'd0);
    check("mid_rst_strobes", 32'({sel, ren, wen, en, busy}), 32'd0);
    check("mid_rst_done", 32'(done_flag), 32'd0);
    snap();
    repeat (100) @(posedge clk);
    #1;
    check("post_rst_wen", 32'(wen_cnt - b_wen), 32'd0);
    check("post_rst_done", 32'(done_flag), 32'd0);

`ifdef NTT_SCHED_STALL_EN
    run_xfer(4'b0000, -100, 20, n);
    check("hold_latency", 32'(n), 32'd715);
    check("hold_flag", 32'(done_flag), 32'd1);
    check("hold_ren", 32'(ren_cnt - b_ren), 32'd640);
    check("hold_wen", 32'(wen_cnt - b_wen), 32'd640);
    check("hold_bnd_bad", 32'(bnd_bad - b_bbad), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
